// File: rtl/sprite_layer_ctrl_if.sv
// Pixel position, sprite configuration, ROM port and pixel result signals of the sprite layer.
// master: video timing / host side; slave: sprite_layer_ctrl.
interface sprite_layer_ctrl_if #(
  parameter int unsigned NUM_SPR    = 4,
  parameter int unsigned NUM_FRAMES = 2,
  parameter int unsigned ADDR_W     = 14
);
  localparam int unsigned IdxW   = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
  localparam int unsigned FrameW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

  // Scan position
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              blank;
  // Shadow register writes
  logic              cfg_we;
  logic [IdxW-1:0]   cfg_idx;
  logic [9:0]        cfg_x;
  logic [9:0]        cfg_y;
  logic              cfg_vis;
  logic              cfg_pending;
  // Sprite ROM
  logic [ADDR_W-1:0] rom_address;
  logic [3:0]        rom_q;
  // Pixel result
  logic [3:0]        pix_index;
  logic              pix_hit;
  logic [IdxW-1:0]   pix_sprite;
  logic [FrameW-1:0] anim_frame;

  modport master (
    output DrawX, DrawY, blank,
    output cfg_we, cfg_idx, cfg_x, cfg_y, cfg_vis,
    output rom_q,
    input  cfg_pending, rom_address, pix_index, pix_hit, pix_sprite, anim_frame
  );

  modport slave (
    input  DrawX, DrawY, blank,
    input  cfg_we, cfg_idx, cfg_x, cfg_y, cfg_vis,
    input  rom_q,
    output cfg_pending, rom_address, pix_index, pix_hit, pix_sprite, anim_frame
  );
endinterface

// File: rtl/sprite_layer_ctrl.sv
// Sprite layer controller: shares one animated sprite ROM among NUM_SPR sprite instances.
// Per pixel it picks the highest-priority (lowest-index) sprite covering (DrawX, DrawY),
// addresses the ROM (including the animation frame offset) and qualifies the returned
// palette index against transparency and blanking. Position/visibility registers are
// double-buffered and, like the animation counter, only change at the start of vblank.
module sprite_layer_ctrl #(
  parameter int unsigned NUM_SPR    = 4,
  parameter int unsigned SPR_W      = 70,
  parameter int unsigned SPR_H      = 70,
  parameter int unsigned NUM_FRAMES = 2,
  parameter int unsigned FRAME_DIV  = 8,
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned V_ACTIVE   = 480,
  parameter logic [3:0]  TRANSP     = 4'h0
) (
  input logic                vga_clk,
  input logic                reset,
  sprite_layer_ctrl_if.slave bus
);
  localparam int unsigned IdxW      = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
  localparam int unsigned FrameW    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int unsigned DivW      = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned FrameSize = SPR_W * SPR_H;

  localparam logic [10:0]       SprW11   = 11'(SPR_W);
  localparam logic [10:0]       SprH11   = 11'(SPR_H);
  localparam logic [9:0]        VActive  = 10'(V_ACTIVE);
  localparam logic [DivW-1:0]   DivMax   = DivW'(FRAME_DIV - 1);
  localparam logic [FrameW-1:0] FrameMax = FrameW'(NUM_FRAMES - 1);

  // Active (used for rendering) and shadow (written by host) sprite registers
  logic [9:0]         act_x_q [NUM_SPR];
  logic [9:0]         act_y_q [NUM_SPR];
  logic [NUM_SPR-1:0] act_vis_q;
  logic [9:0]         shd_x_q [NUM_SPR];
  logic [9:0]         shd_y_q [NUM_SPR];
  logic [NUM_SPR-1:0] shd_vis_q;

  logic [DivW-1:0]    div_q;
  logic [FrameW-1:0]  anim_q;
  logic               pending_q;
  logic [9:0]         prev_y_q;
  logic               apply;

  // Stage 1 (winner / address) and stage 2 (qualified pixel) registers
  logic [ADDR_W-1:0]  rom_addr_q;
  logic               s1_hit_q;
  logic [IdxW-1:0]    s1_idx_q;
  logic               s1_blank_q;
  logic [3:0]         pix_index_q;
  logic               pix_hit_q;
  logic [IdxW-1:0]    pix_sprite_q;

  // Stage 1 combinational results
  logic [NUM_SPR-1:0] hit_vec;
  logic               hit_d;
  logic [IdxW-1:0]    win_d;
  logic [9:0]         win_x;
  logic [9:0]         win_y;
  logic [9:0]         row_off;
  logic [9:0]         col_off;
  logic [ADDR_W-1:0]  addr_d;
  logic               opaque;

  // Start of vblank: first cycle on which DrawY reaches V_ACTIVE
  assign apply = (bus.DrawY == VActive) && (prev_y_q != VActive);

  // Shadow writes, shadow-to-active copy and animation stepping at each apply event.
  // A write on the apply cycle lands in shadow only, so pending stays set for the next one.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_SPR); i++) begin
        act_x_q[i] <= '0;
        act_y_q[i] <= '0;
        shd_x_q[i] <= '0;
        shd_y_q[i] <= '0;
      end
      act_vis_q <= '0;
      shd_vis_q <= '0;
      div_q     <= '0;
      anim_q    <= '0;
      pending_q <= 1'b0;
      prev_y_q  <= VActive;
    end else begin
      prev_y_q <= bus.DrawY;
      if (apply) begin
        for (int i = 0; i < int'(NUM_SPR); i++) begin
          act_x_q[i] <= shd_x_q[i];
          act_y_q[i] <= shd_y_q[i];
        end
        act_vis_q <= shd_vis_q;
        pending_q <= 1'b0;
        if (div_q == DivMax) begin
          div_q  <= '0;
          anim_q <= (anim_q == FrameMax) ? '0 : anim_q + FrameW'(1);
        end else begin
          div_q <= div_q + DivW'(1);
        end
      end
      if (bus.cfg_we) begin
        shd_x_q[bus.cfg_idx]   <= bus.cfg_x;
        shd_y_q[bus.cfg_idx]   <= bus.cfg_y;
        shd_vis_q[bus.cfg_idx] <= bus.cfg_vis;
        pending_q              <= 1'b1;
      end
    end
  end

  // Per-sprite hit test; 11-bit sums keep sprites hanging past 1023 from wrapping to 0.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < int'(NUM_SPR); i++) begin
      hit_vec[i] = act_vis_q[i]
                   && ({1'b0, bus.DrawX} >= {1'b0, act_x_q[i]})
                   && ({1'b0, bus.DrawX} <  ({1'b0, act_x_q[i]} + SprW11))
                   && ({1'b0, bus.DrawY} >= {1'b0, act_y_q[i]})
                   && ({1'b0, bus.DrawY} <  ({1'b0, act_y_q[i]} + SprH11));
    end
  end

  // Priority select: scanning downwards leaves the lowest hitting index as winner.
  always_comb begin
    hit_d = 1'b0;
    win_d = '0;
    win_x = '0;
    win_y = '0;
    for (int i = int'(NUM_SPR) - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_d = 1'b1;
        win_d = IdxW'(i);
        win_x = act_x_q[i];
        win_y = act_y_q[i];
      end
    end
  end

  // ROM address: frame base + row-major offset inside the winning sprite.
  always_comb begin
    row_off = bus.DrawY - win_y;
    col_off = bus.DrawX - win_x;
    addr_d  = '0;
    if (hit_d) begin
      addr_d = ADDR_W'(anim_q) * ADDR_W'(FrameSize)
             + ADDR_W'(row_off) * ADDR_W'(SPR_W)
             + ADDR_W'(col_off);
    end
  end

  // A transparent winner masks the pixel; lower-priority sprites do not show through.
  assign opaque = s1_hit_q && s1_blank_q && (bus.rom_q != TRANSP);

  // Two-stage pixel pipeline: stage 1 registers the ROM request, stage 2 the qualified result.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_addr_q   <= '0;
      s1_hit_q     <= 1'b0;
      s1_idx_q     <= '0;
      s1_blank_q   <= 1'b0;
      pix_index_q  <= '0;
      pix_hit_q    <= 1'b0;
      pix_sprite_q <= '0;
    end else begin
      rom_addr_q   <= addr_d;
      s1_hit_q     <= hit_d;
      s1_idx_q     <= win_d;
      s1_blank_q   <= bus.blank;
      pix_hit_q    <= opaque;
      pix_index_q  <= opaque ? bus.rom_q : 4'h0;
      pix_sprite_q <= s1_idx_q;
    end
  end

  assign bus.rom_address = rom_addr_q;
  assign bus.pix_index   = pix_index_q;
  assign bus.pix_hit     = pix_hit_q;
  assign bus.pix_sprite  = pix_sprite_q;
  assign bus.anim_frame  = anim_q;
  assign bus.cfg_pending = pending_q;
endmodule

// File: tb/tb_sprite_layer_ctrl.sv
// Bench for sprite_layer_ctrl: directed scenarios with literal expectations, then randomized
// pixel/config traffic, all compared every cycle against a behavioural frame-level model.
module tb_sprite_layer_ctrl;
  localparam int NS = 4;
  localparam int SW = 70;
  localparam int SH = 70;
  localparam int NF = 2;
  localparam int FD = 8;
  localparam int VA = 480;

  logic clk;
  logic reset;

  sprite_layer_ctrl_if #(.NUM_SPR(NS), .NUM_FRAMES(NF), .ADDR_W(14)) bus ();

  sprite_layer_ctrl #(
    .NUM_SPR(NS), .SPR_W(SW), .SPR_H(SH), .NUM_FRAMES(NF), .FRAME_DIV(FD),
    .ADDR_W(14), .V_ACTIVE(VA), .TRANSP(4'h0)
  ) dut (
    .vga_clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sprite ROM, read on the falling edge
  logic [3:0] rom_mem [16384];
  always @(negedge clk) bus.rom_q <= rom_mem[bus.rom_address];

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int  m_x [NS], m_y [NS], s_x [NS], s_y [NS];
  bit  m_vis [NS], s_vis [NS];
  int  m_prev_y, m_events;
  bit  m_pending, m_valid;
  bit  ms1_hit, ms1_blank;
  int  ms1_idx, ms1_addr;
  int  e_addr, e_index, e_spr, e_anim;
  bit  e_hit, e_pending;
  int  m_d, m_win, m_anim, m_px, m_py;

  initial begin
    m_valid = 1'b0;
    forever begin
      @(posedge clk);
      if (reset) begin
        for (int i = 0; i < NS; i++) begin
          m_x[i] = 0; m_y[i] = 0; m_vis[i] = 0; s_x[i] = 0; s_y[i] = 0; s_vis[i] = 0;
        end
        m_prev_y = VA; m_events = 0; m_pending = 0;
        ms1_hit = 0; ms1_blank = 0; ms1_idx = 0; ms1_addr = 0;
        e_addr = 0; e_index = 0; e_hit = 0; e_spr = 0;
        m_valid = 1'b1;
      end else begin
        m_anim = (m_events / FD) % NF;
        m_px = int'(bus.DrawX);
        m_py = int'(bus.DrawY);
        // output of the pixel presented one cycle earlier
        m_d = int'(rom_mem[ms1_addr]);
        e_hit = ms1_hit && ms1_blank && (m_d != 0);
        e_index = e_hit ? m_d : 0;
        e_spr = ms1_idx;
        // winner for the current pixel
        m_win = -1;
        for (int i = 0; i < NS; i++)
          if (m_win < 0 && m_vis[i] && m_px >= m_x[i] && m_px < m_x[i] + SW &&
              m_py >= m_y[i] && m_py < m_y[i] + SH) m_win = i;
        ms1_hit = (m_win >= 0);
        ms1_idx = ms1_hit ? m_win : 0;
        ms1_addr = ms1_hit ? m_anim * SW * SH + (m_py - m_y[m_win]) * SW + (m_px - m_x[m_win])
                           : 0;
        ms1_blank = bus.blank;
        e_addr = ms1_addr;
        // frame bookkeeping
        if (m_py == VA && m_prev_y != VA) begin
          for (int i = 0; i < NS; i++) begin
            m_x[i] = s_x[i]; m_y[i] = s_y[i]; m_vis[i] = s_vis[i];
          end
          m_events++;
          m_pending = 0;
        end
        if (bus.cfg_we) begin
          s_x[int'(bus.cfg_idx)] = int'(bus.cfg_x);
          s_y[int'(bus.cfg_idx)] = int'(bus.cfg_y);
          s_vis[int'(bus.cfg_idx)] = bus.cfg_vis;
          m_pending = 1;
        end
        m_prev_y = m_py;
      end
      e_anim = (m_events / FD) % NF;
      e_pending = m_pending;
    end
  end

  // Cycle-by-cycle comparison against the model
  initial forever begin
    @(posedge clk);
    #1;
    if (m_valid) begin
      check("rom_address", int'(bus.rom_address), e_addr);
      check("pix_index", int'(bus.pix_index), e_index);
      check("pix_hit", int'(bus.pix_hit), int'(e_hit));
      check("pix_sprite", int'(bus.pix_sprite), e_spr);
      check("anim_frame", int'(bus.anim_frame), e_anim);
      check("cfg_pending", int'(bus.cfg_pending), int'(e_pending));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int x, input int y, input bit b, input bit we = 1'b0,
                      input int idx = 0, input int cx = 0, input int cy = 0,
                      input bit cv = 1'b0);
    @(negedge clk);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    bus.blank = b;
    bus.cfg_we = we;
    bus.cfg_idx = 2'(idx);
    bus.cfg_x = 10'(cx);
    bus.cfg_y = 10'(cy);
    bus.cfg_vis = cv;
  endtask

  task automatic cfg(input int idx, input int cx, input int cy, input bit cv);
    step(0, 0, 1'b1, 1'b1, idx, cx, cy, cv);
    @(posedge clk); #2;
    check("lit_pending_set", int'(bus.cfg_pending), 1);
  endtask

  task automatic vsync();
    step(0, VA - 1, 1'b0);
    step(0, VA, 1'b0);
    @(posedge clk); #2;
  endtask

  task automatic probe(input string name, input int x, input int y, input bit b,
                       input int ea, input int ehit, input int eidx, input int espr);
    step(x, y, b);
    @(posedge clk); #2;
    check({name, "_addr"}, int'(bus.rom_address), ea);
    check({name, "_model_addr"}, e_addr, ea);
    step(0, 0, 1'b1);
    @(posedge clk); #2;
    check({name, "_hit"}, int'(bus.pix_hit), ehit);
    check({name, "_index"}, int'(bus.pix_index), eidx);
    check({name, "_sprite"}, int'(bus.pix_sprite), espr);
    check({name, "_model_index"}, e_index, eidx);
  endtask

  int w_x [NS], w_y [NS];
  int k, px, py;

  initial begin
    for (int a = 0; a < 16384; a++) rom_mem[a] = 4'($urandom_range(0, 15));
    rom_mem[0] = 4'd5;    rom_mem[2] = 4'd7;    rom_mem[710] = 4'd0;  rom_mem[711] = 4'd9;
    rom_mem[4755] = 4'd11; rom_mem[4899] = 4'd6; rom_mem[4900] = 4'd3;

    reset = 1'b1;
    bus.DrawX = '0; bus.DrawY = '0; bus.blank = 1'b0; bus.cfg_we = 1'b0;
    bus.cfg_idx = '0; bus.cfg_x = '0; bus.cfg_y = '0; bus.cfg_vis = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_addr", int'(bus.rom_address), 0);
    check("rst_hit", int'(bus.pix_hit), 0);
    check("rst_anim", int'(bus.anim_frame), 0);
    check("rst_pending", int'(bus.cfg_pending), 0);
    @(negedge clk) reset = 1'b0;

    // Basic hit, corners and misses
    cfg(0, 100, 50, 1'b1);
    vsync();
    check("lit_pending_clr", int'(bus.cfg_pending), 0);
    probe("origin", 100, 50, 1'b1, 0, 1, 5, 0);
    probe("corner", 169, 119, 1'b1, 4899, 1, 6, 0);
    probe("right_edge", 170, 50, 1'b1, 0, 0, 0, 0);
    probe("bottom_edge", 100, 120, 1'b1, 0, 0, 0, 0);

    // Overlap priority and transparency without fallthrough
    cfg(0, 190, 190, 1'b1);
    cfg(2, 195, 195, 1'b1);
    vsync();
    probe("transp_win", 200, 200, 1'b1, 710, 0, 0, 0);
    probe("overlap", 201, 200, 1'b1, 711, 1, 9, 0);
    probe("spr2_only", 260, 262, 1'b1, 4755, 1, 11, 2);
    probe("blanked", 192, 190, 1'b0, 2, 0, 0, 0);

    // Sprite hanging past column 1023
    cfg(0, 1000, 50, 1'b1);
    vsync();
    probe("no_wrap", 10, 50, 1'b1, 0, 0, 0, 0);
    probe("far_right", 1011, 60, 1'b1, 711, 1, 9, 0);

    // Double buffering: mid-frame write, and write on the apply cycle
    cfg(1, 400, 300, 1'b1);
    vsync();
    cfg(1, 300, 300, 1'b1);
    probe("old_pos_miss", 300, 300, 1'b1, 0, 0, 0, 0);
    probe("old_pos_hit", 400, 300, 1'b1, 0, 1, 5, 1);
    check("lit_pending_mid", int'(bus.cfg_pending), 1);
    step(0, VA - 1, 1'b0);
    step(0, VA, 1'b0, 1'b1, 1, 500, 300, 1'b1);
    @(posedge clk); #2;
    check("lit_pending_coinc", int'(bus.cfg_pending), 1);
    probe("applied_pre", 300, 300, 1'b1, 0, 1, 5, 1);
    probe("not_yet", 500, 300, 1'b1, 0, 0, 0, 0);
    vsync();
    check("lit_pending_clr2", int'(bus.cfg_pending), 0);
    probe("applied_post", 500, 300, 1'b1, 0, 1, 5, 1);

    // Reset mid-line
    step(501, 301, 1'b1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #2;
    check("midrst_addr", int'(bus.rom_address), 0);
    check("midrst_hit", int'(bus.pix_hit), 0);
    check("midrst_sprite", int'(bus.pix_sprite), 0);
    @(negedge clk) reset = 1'b0;

    // Animation
    cfg(0, 100, 50, 1'b1);
    repeat (8) vsync();
    check("lit_anim1", int'(bus.anim_frame), 1);
    probe("frame1", 100, 50, 1'b1, 4900, 1, 3, 0);
    repeat (8) vsync();
    check("lit_anim0", int'(bus.anim_frame), 0);
    probe("frame0", 100, 50, 1'b1, 0, 1, 5, 0);

    // Randomized traffic
    for (int i = 0; i < NS; i++) begin w_x[i] = 0; w_y[i] = 0; end
    w_x[0] = 100; w_y[0] = 50;
    for (int f = 0; f < 14; f++) begin
      if (f == 7) begin
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < NS; i++) begin w_x[i] = 0; w_y[i] = 0; end
      end
      for (int c = 0; c < 250; c++) begin
        k = $urandom_range(0, NS - 1);
        px = (w_x[k] + 1024 + $urandom_range(0, 79) - 5) % 1024;
        py = (w_y[k] + 480 + $urandom_range(0, 79) - 5) % 480;
        if ($urandom_range(0, 15) == 0) begin
          k = $urandom_range(0, NS - 1);
          w_x[k] = $urandom_range(0, 1023);
          w_y[k] = $urandom_range(0, 520);
          step(px, py, $urandom_range(0, 9) != 0, 1'b1, k, w_x[k], w_y[k],
               $urandom_range(0, 3) != 0);
        end else begin
          step(px, py, $urandom_range(0, 9) != 0);
        end
      end
      step(0, VA - 1, 1'b0);
      k = $urandom_range(0, NS - 1);
      if ($urandom_range(0, 2) == 0) begin
        w_x[k] = $urandom_range(0, 1023);
        w_y[k] = $urandom_range(0, 470);
        step(0, VA, 1'b0, 1'b1, k, w_x[k], w_y[k], 1'b1);
      end else begin
        step(0, VA, 1'b0);
      end
      step(0, VA + 1, 1'b0);
    end
    step(0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sprite_layer_ctrl.md
Name: sprite_layer_ctrl

Overview:
- Sequences a single shared sprite ROM among NUM_SPR on-screen sprite instances, all drawn from the same animated sprite sheet.
- Per pixel, resolves which sprite covers (DrawX, DrawY), generates the ROM address including the animation frame offset, and applies transparency.
- Emits a palette index plus a hit flag to the downstream palette/colour mux.
- Holds double-buffered per-sprite position/visibility registers and an animation frame counter, both updated at the start of vertical blank.

Parameters:
NUM_SPR, 4, number of sprite instances; index 0 has highest priority
SPR_W, 70, sprite width in pixels
SPR_H, 70, sprite height in pixels
NUM_FRAMES, 2, animation frames stored back-to-back in ROM
FRAME_DIV, 8, video frames per animation step
ADDR_W, 14, ROM address width; must satisfy NUM_FRAMES*SPR_W*SPR_H <= 2^ADDR_W
V_ACTIVE, 480, first DrawY value of vertical blank
TRANSP, 4'h0, ROM index treated as transparent

Ports:
vga_clk  in  1  pixel clock; DrawX advances once per cycle
reset  in  1  synchronous, active-high
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
blank  in  1  high = visible display region
cfg_we  in  1  write strobe for the shadow sprite registers
cfg_idx  in  $clog2(NUM_SPR)  sprite being written
cfg_x  in  10  sprite top-left column
cfg_y  in  10  sprite top-left row
cfg_vis  in  1  sprite enable
cfg_pending  out  1  a shadow write is waiting for the next apply event
rom_address  out  ADDR_W  address to the sprite ROM; ROM is read on negedge vga_clk
rom_q  in  4  ROM data, valid at the posedge after rom_address is registered
pix_index  out  4  palette index for the pixel
pix_hit  out  1  an opaque sprite pixel is present
pix_sprite  out  $clog2(NUM_SPR)  winning sprite number
anim_frame  out  $clog2(NUM_FRAMES)  current animation frame

Behaviour:
- Reset values:
  - All active and shadow regs: x=0, y=0, vis=0.
  - div counter=0, anim_frame=0, cfg_pending=0.
  - rom_address=0, pix_index=0, pix_hit=0, pix_sprite=0.
  - Internal prev-DrawY register = V_ACTIVE, so no apply event fires on the first post-reset cycle.
- Apply event:
  - Fires for one cycle when DrawY==V_ACTIVE and the registered previous DrawY != V_ACTIVE.
  - At that cycle, all active regs <= shadow regs and cfg_pending <= 0.
  - div counter increments; when it wraps from FRAME_DIV-1 to 0, anim_frame increments modulo NUM_FRAMES.
- Config writes:
  - cfg_we writes shadow[cfg_idx] and sets cfg_pending=1.
  - Active regs never change mid-frame.
  - cfg_we coincident with an apply event: active takes the pre-write shadow, the new write lands in shadow, and cfg_pending stays 1.
- Stage 1 (posedge N):
  - Hit test for each sprite i: vis_i && DrawX>=x_i && DrawX<x_i+SPR_W && DrawY>=y_i && DrawY<y_i+SPR_H.
  - Comparisons use 11-bit sums, so a sprite extending past 1023 neither wraps nor matches at low coordinates.
  - The lowest-index hitting sprite wins.
  - Registers: rom_address <= anim_frame*SPR_W*SPR_H + (DrawY-y_w)*SPR_W + (DrawX-x_w), plus s1_hit, s1_idx, s1_blank.
  - With no hit: rom_address <= 0 and s1_hit <= 0.
- Stage 2 (posedge N+1):
  - pix_index <= rom_q, pix_sprite <= s1_idx.
  - pix_hit <= s1_hit && s1_blank && (rom_q != TRANSP).
  - When pix_hit=0, pix_index <= 0.
- Latency: pixel (DrawX, DrawY) presented at N appears on the pix_* outputs after posedge N+1, i.e. 2 cycles.
- Transparency does not fall through to lower-priority sprites; a transparent winner yields pix_hit=0.
- Reset asserted mid-line clears the pipeline and all regs on the next posedge. Outputs are 0 until two valid cycles have passed after reset deasserts.

Test Plan:
- Reset, then cfg sprite0 (x=100, y=50, vis=1), step DrawY 479->480 -> cfg_pending 1->0. Present (100,50) -> rom_address=0 one cycle later. With rom_q=5: pix_index=5, pix_hit=1, pix_sprite=0 two cycles later.
- Same sprite, corners: (169,119) -> address 4899 (hit); (170,50) and (100,120) -> pix_hit=0. Sprite at x=1000 with DrawX=10 -> no hit.
- Sprite0 and sprite2 overlapping at (200,200) -> pix_sprite=0. Make the rom_q return for sprite0's address TRANSP -> pix_hit=0, no fallthrough to sprite2.
- Write sprite1 x=300 mid-frame -> rendering still uses the old x until the 479->480 transition. cfg_we on exactly that cycle -> old value applied, cfg_pending remains 1.
- Run 8 apply events -> anim_frame=1, and (100,50) gives address 4900. After 16 events -> anim_frame=0.
- blank=0 with a hit and rom_q=7 -> pix_hit=0, pix_index=0. Assert reset mid-line -> all outputs 0 on the following posedge.
